// File: rtl/pw_check_ctrl_pkg.sv
// Shared types and constants for the password lock controller:
// FSM state encoding, the factory password and the one-hot digit check.
package pwlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKOUT
    } state_t;

    typedef logic [9:0]      digit_t;
    // Six one-hot digits; element 0 corresponds to pwds0.
    typedef logic [5:0][9:0] pw_t;

    // Factory password 1-2-3-4-5-6 (pwds0 = digit 1 ... pwds5 = digit 6).
    localparam pw_t DEFAULT_PW = {
        10'b0001000000,
        10'b0000100000,
        10'b0000010000,
        10'b0000001000,
        10'b0000000100,
        10'b0000000010
    };

    function automatic logic digit_valid(input digit_t d);
        return (d != '0) && ((d & (d - 10'd1)) == '0);
    endfunction

endpackage

// File: rtl/pw_check_ctrl_if.sv
// Digit-entry and button bus between the entry/display stage and the lock controller.
interface pw_check_ctrl_if;
    import pwlock_pkg::*;

    digit_t     pwds0;
    digit_t     pwds1;
    digit_t     pwds2;
    digit_t     pwds3;
    digit_t     pwds4;
    digit_t     pwds5;
    logic       confirm;
    logic       set_pw;
    logic       lock;
    logic       unlocked;
    logic       alarm;
    logic [5:0] countdown;
    logic       clear_entry;
    logic [2:0] fails;

    // Entry/display side: drives digits and buttons, consumes status.
    modport master (
        output pwds0, pwds1, pwds2, pwds3, pwds4, pwds5,
        output confirm, set_pw, lock,
        input  unlocked, alarm, countdown, clear_entry, fails
    );

    // Lock controller side.
    modport slave (
        input  pwds0, pwds1, pwds2, pwds3, pwds4, pwds5,
        input  confirm, set_pw, lock,
        output unlocked, alarm, countdown, clear_entry, fails
    );

endinterface

// File: rtl/pw_check_ctrl_sec_countdown.sv
// Seconds down-counter shared by OPEN and LOCKOUT: prescaler plus 6-bit count,
// with a combinational expire pulse on the tick that takes the count from 1 to 0.
module sec_countdown #(
    parameter int TICKS_PER_SEC = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] load_value,
    output logic [5:0] count,
    output logic       expire
);

    localparam int            PRE_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

    logic [PRE_W-1:0] prescaler;
    logic             tick;

    assign tick   = (prescaler == PRE_MAX);
    assign expire = tick && (count == 6'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            count     <= '0;
        end else if (load) begin
            prescaler <= '0;
            count     <= load_value;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick && (count != 6'd0))
                count <= count - 6'd1;
        end
    end

endmodule

// File: rtl/pw_check_ctrl.sv
// Lock controller: checks the six-digit entry on confirm, counts failures,
// enforces timed lockout, auto-relocks when open and allows password change.
module pw_check_ctrl
    import pwlock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 400,
    parameter int OPEN_SECS     = 10,
    parameter int LOCKOUT_SECS  = 30,
    parameter int MAX_FAILS     = 3
) (
    input  logic          clk_400hz,
    input  logic          reset,
    pw_check_ctrl_if.slave bus
);

    localparam logic [5:0] OPEN_VAL    = 6'(OPEN_SECS);
    localparam logic [5:0] LOCKOUT_VAL = 6'(LOCKOUT_SECS);
    localparam logic [2:0] FAIL_LIMIT  = 3'(MAX_FAILS);

    state_t     state, state_next;
    pw_t        password, password_next;
    pw_t        entry;
    logic [2:0] fails, fails_next, fails_inc;
    logic       clear_entry, clear_next;
    logic       unlocked, alarm;
    logic       confirm_q, set_pw_q, lock_q;
    logic       confirm_press, set_pw_press, lock_press;
    logic       complete;
    logic       cd_load, expire;
    logic [5:0] cd_value, countdown;

    assign entry = {bus.pwds5, bus.pwds4, bus.pwds3, bus.pwds2, bus.pwds1, bus.pwds0};

    assign confirm_press = bus.confirm & ~confirm_q;
    assign set_pw_press  = bus.set_pw  & ~set_pw_q;
    assign lock_press    = bus.lock    & ~lock_q;
    assign fails_inc     = fails + 3'd1;

    always_comb begin
        complete = 1'b1;
        for (int i = 0; i < 6; i++)
            if (!digit_valid(entry[i]))
                complete = 1'b0;
    end

    sec_countdown #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_timer (
        .clk        (clk_400hz),
        .reset      (reset),
        .load       (cd_load),
        .load_value (cd_value),
        .count      (countdown),
        .expire     (expire)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and infers a latch.
        state_next    = state;
        fails_next    = fails;
        password_next = password;
        clear_next    = 1'b0;
        cd_load       = 1'b0;
        cd_value      = '0;

        unique case (state)
            ST_IDLE: begin
                if (confirm_press && complete)
                    state_next = ST_CHECK;
            end
            ST_CHECK: begin
                clear_next = 1'b1;
                if (entry == password) begin
                    state_next = ST_OPEN;
                    fails_next = '0;
                    cd_load    = 1'b1;
                    cd_value   = OPEN_VAL;
                end else if (fails_inc < FAIL_LIMIT) begin
                    state_next = ST_IDLE;
                    fails_next = fails_inc;
                end else begin
                    state_next = ST_LOCKOUT;
                    fails_next = FAIL_LIMIT;
                    cd_load    = 1'b1;
                    cd_value   = LOCKOUT_VAL;
                end
            end
            ST_OPEN: begin
                // Lock beats set_pw, which beats timer expiry.
                if (lock_press) begin
                    state_next = ST_IDLE;
                    clear_next = 1'b1;
                    cd_load    = 1'b1;
                end else if (set_pw_press && complete) begin
                    password_next = entry;
                    clear_next    = 1'b1;
                    cd_load       = 1'b1;
                    cd_value      = OPEN_VAL;
                end else if (expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (expire) begin
                    state_next = ST_IDLE;
                    fails_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Entry stays blanked for the whole lockout.
        if (state_next == ST_LOCKOUT)
            clear_next = 1'b1;
    end

    always_ff @(posedge clk_400hz) begin
        if (reset) begin
            state       <= ST_IDLE;
            fails       <= '0;
            // NOTE: the password register is reset on purpose: reset must
            // restore the factory password, not keep a user-set one.
            password    <= DEFAULT_PW;
            clear_entry <= 1'b0;
            unlocked    <= 1'b0;
            alarm       <= 1'b0;
            confirm_q   <= 1'b0;
            set_pw_q    <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state       <= state_next;
            fails       <= fails_next;
            password    <= password_next;
            clear_entry <= clear_next;
            unlocked    <= (state_next == ST_OPEN);
            alarm       <= (state_next == ST_LOCKOUT);
            confirm_q   <= bus.confirm;
            set_pw_q    <= bus.set_pw;
            lock_q      <= bus.lock;
        end
    end

    assign bus.unlocked    = unlocked;
    assign bus.alarm       = alarm;
    assign bus.countdown   = countdown;
    assign bus.clear_entry = clear_entry;
    assign bus.fails       = fails;

endmodule

// File: tb/tb_pw_check_ctrl.sv
// Directed bench for pw_check_ctrl with TICKS_PER_SEC=4, OPEN_SECS=3,
// LOCKOUT_SECS=2, MAX_FAILS=3; expected values are hand-computed.
module tb_pw_check_ctrl;
    import pwlock_pkg::*;

    localparam pw_t PW_123456 = {
        10'b0001000000, 10'b0000100000, 10'b0000010000,
        10'b0000001000, 10'b0000000100, 10'b0000000010
    };
    localparam pw_t PW_123457 = {
        10'b0010000000, 10'b0000100000, 10'b0000010000,
        10'b0000001000, 10'b0000000100, 10'b0000000010
    };
    localparam pw_t PW_12345E = {
        10'b0000000000, 10'b0000100000, 10'b0000010000,
        10'b0000001000, 10'b0000000100, 10'b0000000010
    };
    localparam pw_t PW_990011 = {
        10'b0000000010, 10'b0000000010, 10'b0000000001,
        10'b0000000001, 10'b1000000000, 10'b1000000000
    };

    logic clk_400hz = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   clear_cycles;

    pw_check_ctrl_if bus();

    pw_check_ctrl #(
        .TICKS_PER_SEC(4),
        .OPEN_SECS    (3),
        .LOCKOUT_SECS (2),
        .MAX_FAILS    (3)
    ) dut (
        .clk_400hz (clk_400hz),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_400hz = ~clk_400hz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_400hz);
            #1;
        end
    endtask

    task automatic set_entry(input pw_t e);
        bus.pwds0 = e[0];
        bus.pwds1 = e[1];
        bus.pwds2 = e[2];
        bus.pwds3 = e[3];
        bus.pwds4 = e[4];
        bus.pwds5 = e[5];
    endtask

    // Confirm press sampled at edge N; returns after edge N+1.
    task automatic press_confirm();
        bus.confirm = 1'b1;
        step(1);
        bus.confirm = 1'b0;
        step(1);
    endtask

    initial begin
        reset       = 1'b1;
        bus.confirm = 1'b0;
        bus.set_pw  = 1'b0;
        bus.lock    = 1'b0;
        set_entry('0);
        step(2);
        reset = 1'b0;

        check("rst_unlocked",  32'(bus.unlocked),    0);
        check("rst_alarm",     32'(bus.alarm),       0);
        check("rst_countdown", 32'(bus.countdown),   0);
        check("rst_clear",     32'(bus.clear_entry), 0);
        check("rst_fails",     32'(bus.fails),       0);

        // Correct password and auto-relock timing.
        set_entry(PW_123456);
        bus.confirm = 1'b1;
        step(1);
        bus.confirm = 1'b0;
        check("check_cycle_unlocked", 32'(bus.unlocked),    0);
        check("check_cycle_clear",    32'(bus.clear_entry), 0);
        step(1);
        check("open_unlocked",  32'(bus.unlocked),    1);
        check("open_countdown", 32'(bus.countdown),   3);
        check("open_clear",     32'(bus.clear_entry), 1);
        step(1);
        check("open_clear_width", 32'(bus.clear_entry), 0);
        step(2);
        check("open_cd_n4", 32'(bus.countdown), 3);
        step(1);
        check("open_cd_n5", 32'(bus.countdown), 2);
        step(7);
        check("open_cd_n12",       32'(bus.countdown), 1);
        check("open_unlocked_n12", 32'(bus.unlocked),  1);
        step(1);
        check("relock_unlocked",  32'(bus.unlocked),  0);
        check("relock_countdown", 32'(bus.countdown), 0);

        // Three failures lead to lockout.
        set_entry(PW_123457);
        press_confirm();
        check("fail1_fails", 32'(bus.fails),       1);
        check("fail1_clear", 32'(bus.clear_entry), 1);
        check("fail1_alarm", 32'(bus.alarm),       0);
        press_confirm();
        check("fail2_fails", 32'(bus.fails), 2);
        press_confirm();
        check("lock_alarm",     32'(bus.alarm),       1);
        check("lock_countdown", 32'(bus.countdown),   2);
        check("lock_fails",     32'(bus.fails),       3);
        check("lock_clear",     32'(bus.clear_entry), 1);
        clear_cycles = 1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (!bus.clear_entry) break;
            clear_cycles++;
        end
        check("lock_clear_cycles", 32'(clear_cycles), 8);
        check("lock_end_alarm",    32'(bus.alarm),     0);
        check("lock_end_fails",    32'(bus.fails),     0);
        check("lock_end_cd",       32'(bus.countdown), 0);

        // Incomplete entry is ignored.
        set_entry(PW_12345E);
        press_confirm();
        check("incomplete_clear",    32'(bus.clear_entry), 0);
        check("incomplete_fails",    32'(bus.fails),       0);
        check("incomplete_unlocked", 32'(bus.unlocked),    0);
        step(1);
        check("incomplete_clear2", 32'(bus.clear_entry), 0);

        // Change password while open.
        set_entry(PW_123456);
        press_confirm();
        check("reopen_unlocked", 32'(bus.unlocked), 1);
        set_entry(PW_990011);
        step(4);
        check("pre_setpw_cd", 32'(bus.countdown), 2);
        bus.set_pw = 1'b1;
        step(1);
        bus.set_pw = 1'b0;
        check("setpw_cd",       32'(bus.countdown),   3);
        check("setpw_clear",    32'(bus.clear_entry), 1);
        check("setpw_unlocked", 32'(bus.unlocked),    1);
        step(1);
        bus.lock = 1'b1;
        step(1);
        bus.lock = 1'b0;
        check("lockbtn_unlocked", 32'(bus.unlocked),    0);
        check("lockbtn_clear",    32'(bus.clear_entry), 1);
        check("lockbtn_cd",       32'(bus.countdown),   0);
        step(1);
        set_entry(PW_123456);
        press_confirm();
        check("oldpw_fails",    32'(bus.fails),    1);
        check("oldpw_unlocked", 32'(bus.unlocked), 0);
        set_entry(PW_990011);
        press_confirm();
        check("newpw_unlocked", 32'(bus.unlocked), 1);
        check("newpw_fails",    32'(bus.fails),    0);

        // Lock and set_pw together: lock wins, password unchanged.
        set_entry(PW_123456);
        bus.lock   = 1'b1;
        bus.set_pw = 1'b1;
        step(1);
        bus.lock   = 1'b0;
        bus.set_pw = 1'b0;
        check("both_unlocked", 32'(bus.unlocked), 0);
        step(1);
        press_confirm();
        check("both_oldpw_fails",    32'(bus.fails),    1);
        check("both_oldpw_unlocked", 32'(bus.unlocked), 0);
        set_entry(PW_990011);
        press_confirm();
        check("both_newpw_unlocked", 32'(bus.unlocked), 1);

        // Reset in the middle of a lockout.
        bus.lock = 1'b1;
        step(1);
        bus.lock = 1'b0;
        step(1);
        set_entry(PW_123456);
        press_confirm();
        press_confirm();
        press_confirm();
        check("lock2_alarm", 32'(bus.alarm), 1);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midrst_alarm",     32'(bus.alarm),       0);
        check("midrst_countdown", 32'(bus.countdown),   0);
        check("midrst_fails",     32'(bus.fails),       0);
        check("midrst_clear",     32'(bus.clear_entry), 0);
        press_confirm();
        check("defpw_unlocked", 32'(bus.unlocked), 1);
        check("defpw_cd",       32'(bus.countdown), 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
